// File: rtl/ieee_add_shift_multiplier.sv
// Sequential binary32 multiplier: radix-2 add-shift mantissa product (one bit per clock),
// followed by a two-cycle normalise/round/pack stage. The result register holds the last product.
module ieee_add_shift_multiplier (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] number1,
    input  logic [31:0] number2,
    input  logic        op,
    output logic [31:0] result
);

    typedef enum logic [1:0] {IDLE, MUL, ROUND} state_t;

    state_t             state;
    logic [31:0]        a_reg;
    logic [31:0]        b_reg;
    logic [23:0]        mcand;
    logic [23:0]        mplier;
    logic [47:0]        acc;
    logic [4:0]         count;
    logic               round_phase;
    logic [22:0]        stage_mant;
    logic signed [9:0]  stage_exp;

    // The multiplicand is added into the top half of the accumulator; the
    // carry becomes bit 47 after the right shift.
    logic [24:0] add_sum;
    assign add_sum = {1'b0, acc[47:24]} + (mplier[0] ? {1'b0, mcand} : 25'd0);

    logic              norm_hi;
    logic [23:0]       mant24;
    logic              round_bit;
    logic              sticky;
    logic              round_up;
    logic [24:0]       rounded;
    logic signed [9:0] exp_base;
    logic signed [9:0] rnd_exp;
    logic [22:0]       rnd_mant;

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        norm_hi   = acc[47];
        mant24    = norm_hi ? acc[47:24] : acc[46:23];
        round_bit = norm_hi ? acc[23] : acc[22];
        sticky    = norm_hi ? (|acc[22:0]) : (|acc[21:0]);
        round_up  = round_bit & (sticky | mant24[0]);
        rounded   = {1'b0, mant24} + {24'd0, round_up};
        exp_base  = $signed({2'b00, a_reg[30:23]}) + $signed({2'b00, b_reg[30:23]})
                  - 10'sd127 + $signed({9'd0, norm_hi});
        rnd_exp   = exp_base + $signed({9'd0, rounded[24]});
        rnd_mant  = rounded[24] ? rounded[23:1] : rounded[22:0];
    end

    logic        sign;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [31:0] packed_result;

    // Subnormal operands count as zero; special cases override the datapath product.
    always_comb begin
        sign   = a_reg[31] ^ b_reg[31];
        a_nan  = (&a_reg[30:23]) & (|a_reg[22:0]);
        b_nan  = (&b_reg[30:23]) & (|b_reg[22:0]);
        a_inf  = (&a_reg[30:23]) & ~(|a_reg[22:0]);
        b_inf  = (&b_reg[30:23]) & ~(|b_reg[22:0]);
        a_zero = ~(|a_reg[30:23]);
        b_zero = ~(|b_reg[30:23]);
        packed_result = {sign, stage_exp[7:0], stage_mant};
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
            packed_result = 32'h7FC0_0000;
        else if (a_inf || b_inf)
            packed_result = {sign, 8'hFF, 23'd0};
        else if (a_zero || b_zero)
            packed_result = {sign, 31'd0};
        else if (stage_exp >= 10'sd255)
            packed_result = {sign, 8'hFF, 23'd0};
        else if (stage_exp <= 10'sd0)
            packed_result = {sign, 31'd0};
    end

    // NOTE: the whole datapath, not just the FSM, is reset so an aborted operation leaves no residue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            mcand       <= '0;
            mplier      <= '0;
            acc         <= '0;
            count       <= '0;
            round_phase <= 1'b0;
            stage_mant  <= '0;
            stage_exp   <= '0;
            result      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (op) begin
                        a_reg       <= number1;
                        b_reg       <= number2;
                        mcand       <= {1'b1, number1[22:0]};
                        mplier      <= {1'b1, number2[22:0]};
                        acc         <= '0;
                        count       <= '0;
                        round_phase <= 1'b0;
                        state       <= MUL;
                    end
                end
                MUL: begin
                    acc    <= {add_sum, acc[23:1]};
                    mplier <= mplier >> 1;
                    count  <= count + 5'd1;
                    if (count == 5'd23)
                        state <= ROUND;
                end
                ROUND: begin
                    if (!round_phase) begin
                        stage_mant  <= rnd_mant;
                        stage_exp   <= rnd_exp;
                        round_phase <= 1'b1;
                    end else begin
                        result      <= packed_result;
                        round_phase <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ieee_add_shift_multiplier.sv
// Directed-vector bench for ieee_add_shift_multiplier with hand-computed binary32 products.
module tb_ieee_add_shift_multiplier;

    logic        clk;
    logic        rst_n;
    logic [31:0] number1;
    logic [31:0] number2;
    logic        op;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;

    ieee_add_shift_multiplier dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .number1 (number1),
        .number2 (number2),
        .op      (op),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Start edge is the posedge after the first negedge; the product lands on
    // the 26th edge after it, i.e. after 27 posedges have passed.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold,
                          input logic [31:0] prev, input logic [31:0] exp, input string tag);
        @(negedge clk);
        number1 = a;
        number2 = b;
        op      = 1'b1;
        repeat (hold) @(negedge clk);
        op = 1'b0;
        repeat (26 - hold) @(negedge clk);
        check({tag, "_early"}, result, prev);
        @(negedge clk);
        check(tag, result, exp);
    endtask

    initial begin
        rst_n   = 1'b0;
        number1 = '0;
        number2 = '0;
        op      = 1'b0;
        repeat (3) @(negedge clk);
        check("reset", result, 32'h0);
        rst_n = 1'b1;

        run_op(32'h3BA3D70A, 32'h3C16BB99, 3, 32'h0,        32'h3840F020, "held3");
        repeat (30) @(negedge clk);
        check("held3_single", result, 32'h3840F020);
        run_op(32'h42E50000, 32'h411FD70A, 1, 32'h3840F020, 32'h448EFB5C, "round_up");
        run_op(32'h3F800000, 32'hC0000000, 1, 32'h448EFB5C, 32'hC0000000, "one_x_m2");
        run_op(32'h00000000, 32'hC2C80000, 1, 32'hC0000000, 32'h80000000, "zero_x_neg");
        run_op(32'h7F800000, 32'h00000000, 1, 32'h80000000, 32'h7FC00000, "inf_x_zero");
        run_op(32'h7F000000, 32'h7F000000, 1, 32'h7FC00000, 32'h7F800000, "overflow");
        run_op(32'h00800000, 32'h00800000, 1, 32'h7F800000, 32'h00000000, "underflow");
        run_op(32'h7F800000, 32'hC0000000, 1, 32'h00000000, 32'hFF800000, "inf_x_fin");
        run_op(32'h7FC00001, 32'h3F800000, 1, 32'hFF800000, 32'h7FC00000, "nan_in");

        // Held op: second operation starts on the edge right after the first completes.
        @(negedge clk);
        number1 = 32'h3F800000;
        number2 = 32'hC0000000;
        op      = 1'b1;
        repeat (26) @(negedge clk);
        number1 = 32'h42E50000;
        number2 = 32'h411FD70A;
        @(negedge clk);
        check("retrig_first", result, 32'hC0000000);
        @(negedge clk);
        op = 1'b0;
        repeat (25) @(negedge clk);
        check("retrig_early", result, 32'hC0000000);
        @(negedge clk);
        check("retrig_second", result, 32'h448EFB5C);

        // Reset in the middle of MUL clears the result at once.
        @(negedge clk);
        number1 = 32'h3BA3D70A;
        number2 = 32'h3C16BB99;
        op      = 1'b1;
        @(negedge clk);
        op = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_reset", result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("after_abort", result, 32'h0);
        run_op(32'h42E50000, 32'h411FD70A, 1, 32'h0, 32'h448EFB5C, "post_reset");

        // Operand changes and op pulses during MUL must not disturb the operation.
        @(negedge clk);
        number1 = 32'h3F800000;
        number2 = 32'hC0000000;
        op      = 1'b1;
        @(negedge clk);
        op = 1'b0;
        repeat (5) @(negedge clk);
        number1 = 32'h40400000;
        number2 = 32'h40000000;
        op      = 1'b1;
        @(negedge clk);
        op = 1'b0;
        repeat (19) @(negedge clk);
        check("capture_early", result, 32'h448EFB5C);
        @(negedge clk);
        check("capture", result, 32'hC0000000);
        repeat (30) @(negedge clk);
        check("capture_hold", result, 32'hC0000000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
